// File: rtl/ps2_kbd_ctrl_if.sv
// Bus between the PS/2 byte receiver, the scan-code controller and the event consumer.
// The slave modport is the controller's view; the master modport is the receiver/consumer side.
interface ps2_kbd_ctrl_if #(
  parameter int unsigned DEPTH = 8
);
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic          rx_done_tick;
  logic [7:0]    rx_data;
  logic          rx_en;
  logic          rd_en;
  logic          ev_valid;
  logic [7:0]    ev_code;
  logic          ev_ext;
  logic          ev_brk;
  logic [CW-1:0] ev_count;
  logic          ovf;
  logic          err;
  logic          clr_flags;

  modport master (
    output rx_done_tick, rx_data, rd_en, clr_flags,
    input  rx_en, ev_valid, ev_code, ev_ext, ev_brk, ev_count, ovf, err
  );

  modport slave (
    input  rx_done_tick, rx_data, rd_en, clr_flags,
    output rx_en, ev_valid, ev_code, ev_ext, ev_brk, ev_count, ovf, err
  );
endinterface

// File: rtl/ps2_kbd_ctrl.sv
// PS/2 set-2 scan-code controller: folds E0/F0 prefixes into key events and queues them in a
// first-word-fall-through FIFO. Define PS2_PREFIX_TIMEOUT_EN to abandon stale prefixes.
module ps2_kbd_ctrl #(
  parameter int unsigned DEPTH       = 8,
  parameter int unsigned TIMEOUT_CYC = 2000000
) (
  input  logic           i_clk,
  input  logic           i_reset,  // active low, asynchronous
  ps2_kbd_ctrl_if.slave  bus
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_depth_chk
    $error("DEPTH must be a power of 2 and at least 2");
  end
  if (TIMEOUT_CYC < 2) begin : g_tmo_chk
    $error("TIMEOUT_CYC must be at least 2");
  end

  typedef enum logic [1:0] {
    StIdle,
    StE0,
    StF0,
    StE0F0
  } state_e;

  state_e        r_state;
  state_e        w_state_nxt;
  logic          w_push;
  logic [9:0]    w_push_data;
  logic          w_err_set;
  logic          w_timeout;
  logic [7:0]    w_byte;
  logic          w_bad;
  logic          w_resp;
  logic          w_prefix;

  logic [9:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [CW-1:0] r_count;
  logic          r_ovf;
  logic          r_err;
  logic          w_full;
  logic          w_empty;
  logic          w_pop;
  logic          w_wr;
  logic          w_drop;

  assign w_byte   = bus.rx_data;
  assign w_bad    = (w_byte == 8'h00) || (w_byte == 8'hFF);
  assign w_resp   = (w_byte == 8'hFA) || (w_byte == 8'hAA) ||
                    (w_byte == 8'hEE) || (w_byte == 8'hFE);
  assign w_prefix = (w_byte == 8'hE0) || (w_byte == 8'hF0);

  // ---------------------------------------------------------------------------------------------
  // Prefix decoder
  // ---------------------------------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_push      = 1'b0;
    w_push_data = {2'b00, w_byte};
    w_err_set   = 1'b0;
    if (bus.rx_done_tick) begin
      unique case (r_state)
        StIdle: begin
          if (w_byte == 8'hE0) begin
            w_state_nxt = StE0;
          end else if (w_byte == 8'hF0) begin
            w_state_nxt = StF0;
          end else if (w_bad) begin
            w_err_set = 1'b1;
          end else if (!w_resp) begin
            w_push = 1'b1;
          end
        end
        StE0: begin
          if (w_byte == 8'hF0) begin
            w_state_nxt = StE0F0;
          end else if (w_byte == 8'hE0) begin
            w_state_nxt = StE0;
          end else if (w_bad) begin
            w_err_set   = 1'b1;
            w_state_nxt = StIdle;
          end else begin
            w_push      = 1'b1;
            w_push_data = {2'b10, w_byte};
            w_state_nxt = StIdle;
          end
        end
        StF0, StE0F0: begin
          w_state_nxt = StIdle;
          // A second prefix after a break prefix is malformed and is dropped.
          if (w_bad || w_prefix) begin
            w_err_set = 1'b1;
          end else begin
            w_push      = 1'b1;
            w_push_data = {(r_state == StE0F0), 1'b1, w_byte};
          end
        end
      endcase
    end else if (w_timeout) begin
      w_state_nxt = StIdle;
      w_err_set   = 1'b1;
    end
  end

`ifdef PS2_PREFIX_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYC);

  logic [TW-1:0] r_tmo_cnt;

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_tmo_cnt <= '0;
    end else if (bus.rx_done_tick || (r_state == StIdle)) begin
      r_tmo_cnt <= '0;
    end else begin
      r_tmo_cnt <= r_tmo_cnt + 1'b1;
    end
  end

  // A byte arriving in the expiry cycle wins because the decoder checks rx_done_tick first.
  assign w_timeout = (r_state != StIdle) && (r_tmo_cnt == TW'(TIMEOUT_CYC - 1));
`else
  assign w_timeout = 1'b0;
`endif

  // ---------------------------------------------------------------------------------------------
  // Event FIFO
  // ---------------------------------------------------------------------------------------------
  assign w_full  = (r_count == CW'(DEPTH));
  assign w_empty = (r_count == '0);
  assign w_pop   = bus.rd_en && !w_empty;
  // A pop in the same cycle frees a slot, so a push into a full FIFO still lands.
  assign w_wr    = w_push && (!w_full || w_pop);
  assign w_drop  = w_push && w_full && !w_pop;

  always_ff @(posedge i_clk) begin
    if (w_wr) begin
      r_mem[r_wptr] <= w_push_data;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_wr) begin
        r_wptr <= r_wptr + 1'b1;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + 1'b1;
      end
      if (w_wr && !w_pop) begin
        r_count <= r_count + 1'b1;
      end else if (!w_wr && w_pop) begin
        r_count <= r_count - 1'b1;
      end
    end
  end

  // Sticky flags: a set in the same cycle as clr_flags wins.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_ovf <= 1'b0;
      r_err <= 1'b0;
    end else begin
      if (w_drop) begin
        r_ovf <= 1'b1;
      end else if (bus.clr_flags) begin
        r_ovf <= 1'b0;
      end
      if (w_err_set) begin
        r_err <= 1'b1;
      end else if (bus.clr_flags) begin
        r_err <= 1'b0;
      end
    end
  end

  assign bus.rx_en    = !w_full;
  assign bus.ev_valid = !w_empty;
  assign bus.ev_count = r_count;
  assign bus.ovf      = r_ovf;
  assign bus.err      = r_err;
  // Masked while empty so the head outputs read zero instead of stale storage.
  assign {bus.ev_ext, bus.ev_brk, bus.ev_code} = w_empty ? 10'h000 : r_mem[r_rptr];

endmodule

// File: tb/tb_ps2_kbd_ctrl.sv
// Directed self-checking bench for ps2_kbd_ctrl; head events are compared as {ext, brk, code}.
// Inputs change on the falling edge and outputs are sampled on the falling edge.
module tb_ps2_kbd_ctrl;
  logic clk;
  logic reset_n;
  int   n_checks;
  int   n_fail;

  ps2_kbd_ctrl_if #(.DEPTH(8)) bus ();

  ps2_kbd_ctrl #(
    .DEPTH       (8),
    .TIMEOUT_CYC (16)
  ) dut (
    .i_clk   (clk),
    .i_reset (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] head();
    return {22'd0, bus.ev_ext, bus.ev_brk, bus.ev_code};
  endfunction

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    bus.rx_done_tick = 1'b1;
    bus.rx_data      = b;
    @(negedge clk);
    bus.rx_done_tick = 1'b0;
  endtask

  task automatic pop();
    @(negedge clk);
    bus.rd_en = 1'b1;
    @(negedge clk);
    bus.rd_en = 1'b0;
  endtask

  task automatic clr_flags();
    @(negedge clk);
    bus.clr_flags = 1'b1;
    @(negedge clk);
    bus.clr_flags = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_checks         = 0;
    n_fail           = 0;
    reset_n          = 1'b0;
    bus.rx_done_tick = 1'b0;
    bus.rx_data      = 8'h00;
    bus.rd_en        = 1'b0;
    bus.clr_flags    = 1'b0;
    repeat (3) @(negedge clk);

    check_eq("rst_valid", 32'(bus.ev_valid), 32'd0);
    check_eq("rst_count", 32'(bus.ev_count), 32'd0);
    check_eq("rst_head",  head(), 32'h000);
    check_eq("rst_ovf",   32'(bus.ovf), 32'd0);
    check_eq("rst_err",   32'(bus.err), 32'd0);
    check_eq("rst_rx_en", 32'(bus.rx_en), 32'd1);
    reset_n = 1'b1;
    @(negedge clk);

    // Plain make code, visible one cycle after the strobe.
    send_byte(8'h1C);
    check_eq("make_valid", 32'(bus.ev_valid), 32'd1);
    check_eq("make_head",  head(), 32'h01C);
    check_eq("make_count", 32'(bus.ev_count), 32'd1);
    pop();
    check_eq("make_pop_valid", 32'(bus.ev_valid), 32'd0);

    // Popping an empty FIFO is ignored.
    pop();
    check_eq("underflow_count", 32'(bus.ev_count), 32'd0);

    // Extended break then plain break.
    send_byte(8'hE0);
    send_byte(8'hF0);
    check_eq("prefix_no_push", 32'(bus.ev_count), 32'd0);
    send_byte(8'h75);
    send_byte(8'hF0);
    send_byte(8'h1C);
    check_eq("brk_count", 32'(bus.ev_count), 32'd2);
    check_eq("ext_brk_head", head(), 32'h375);
    pop();
    check_eq("brk_head", head(), 32'h11C);
    pop();
    check_eq("brk_drained", 32'(bus.ev_valid), 32'd0);

    // Device response discarded; 0xFF flags an error.
    send_byte(8'hFA);
    check_eq("resp_count", 32'(bus.ev_count), 32'd0);
    check_eq("resp_err",   32'(bus.err), 32'd0);
    send_byte(8'hFF);
    check_eq("ff_err",   32'(bus.err), 32'd1);
    check_eq("ff_count", 32'(bus.ev_count), 32'd0);
    clr_flags();
    check_eq("err_clr", 32'(bus.err), 32'd0);

    // Fill, overflow, then drain across the pointer wrap.
    for (int i = 1; i <= 8; i++) send_byte(8'(i));
    check_eq("full_count", 32'(bus.ev_count), 32'd8);
    check_eq("full_rx_en", 32'(bus.rx_en), 32'd0);
    send_byte(8'h09);
    check_eq("ovf_set",   32'(bus.ovf), 32'd1);
    check_eq("ovf_count", 32'(bus.ev_count), 32'd8);
    // Drop and clear in the same cycle: the set wins.
    @(negedge clk);
    bus.rx_done_tick = 1'b1;
    bus.rx_data      = 8'h0A;
    bus.clr_flags    = 1'b1;
    @(negedge clk);
    bus.rx_done_tick = 1'b0;
    bus.clr_flags    = 1'b0;
    check_eq("ovf_set_wins", 32'(bus.ovf), 32'd1);
    clr_flags();
    check_eq("ovf_clr", 32'(bus.ovf), 32'd0);
    for (int i = 1; i <= 8; i++) begin
      check_eq($sformatf("drain_%0d", i), head(), 32'(i));
      pop();
    end
    check_eq("drain_rx_en", 32'(bus.rx_en), 32'd1);
    check_eq("drain_count", 32'(bus.ev_count), 32'd0);

    // Push and pop together while full.
    for (int i = 0; i < 8; i++) send_byte(8'(8'h11 + i));
    @(negedge clk);
    bus.rd_en        = 1'b1;
    bus.rx_done_tick = 1'b1;
    bus.rx_data      = 8'h2A;
    @(negedge clk);
    bus.rd_en        = 1'b0;
    bus.rx_done_tick = 1'b0;
    check_eq("pp_count", 32'(bus.ev_count), 32'd8);
    check_eq("pp_ovf",   32'(bus.ovf), 32'd0);
    for (int i = 0; i < 7; i++) begin
      check_eq($sformatf("pp_drain_%0d", i), head(), 32'(8'h12 + i));
      pop();
    end
    check_eq("pp_last", head(), 32'h02A);
    pop();

    // Repeated E0 stays extended; prefix after F0 is an error with no push.
    send_byte(8'hE0);
    send_byte(8'hE0);
    send_byte(8'h6B);
    check_eq("e0e0_head", head(), 32'h26B);
    pop();
    send_byte(8'hF0);
    send_byte(8'hE0);
    check_eq("f0e0_err",   32'(bus.err), 32'd1);
    check_eq("f0e0_count", 32'(bus.ev_count), 32'd0);
    send_byte(8'h1C);
    check_eq("f0e0_next", head(), 32'h01C);
    clr_flags();

    // Asynchronous reset mid-prefix flushes everything.
    send_byte(8'hE0);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    check_eq("arst_count", 32'(bus.ev_count), 32'd0);
    check_eq("arst_valid", 32'(bus.ev_valid), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    send_byte(8'h1C);
    check_eq("arst_next", head(), 32'h01C);
    pop();

`ifdef PS2_PREFIX_TIMEOUT_EN
    send_byte(8'hE0);
    repeat (15) @(negedge clk);
    check_eq("tmo_early", 32'(bus.err), 32'd0);
    @(negedge clk);
    check_eq("tmo_err", 32'(bus.err), 32'd1);
    check_eq("tmo_count", 32'(bus.ev_count), 32'd0);
    send_byte(8'h1C);
    check_eq("tmo_next", head(), 32'h01C);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
